// File: rtl/midas_timestamper_pkg.sv
// Shared definitions for the multi-channel timestamper: time width and the
// {data, time} entry layout buffered per channel.
package midas_timestamper_pkg;

    localparam int TIME_WIDTH         = 64;
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Entry layout at the default data width; the top re-declares the same
    // layout at its own DATA_WIDTH.
    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] data;
        logic [TIME_WIDTH-1:0]         tstamp;
    } ts_entry_t;

    function automatic int chan_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timestamp_fifo.sv
// Per-channel FIFO with registered full/empty flags. Pushes into a full FIFO
// are dropped even when a pop happens in the same cycle; no write-through.
module timestamp_fifo #(
    parameter int WIDTH      = 72,
    parameter int LOG2_DEPTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] PTR_ONE = 1;

    logic [LOG2_DEPTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                full_q, full_d, empty_q, empty_d;
    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [WIDTH-1:0]    mem_d [DEPTH];
    logic                do_push, do_pop;

    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[LOG2_DEPTH-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        // Extra pointer bit distinguishes full from empty when indices match.
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[LOG2_DEPTH-1:0] == rd_ptr_d[LOG2_DEPTH-1:0]) &&
                  (wr_ptr_d[LOG2_DEPTH] != rd_ptr_d[LOG2_DEPTH]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign head  = mem_q[rd_ptr_q[LOG2_DEPTH-1:0]];

endmodule

// File: rtl/multi_channel_reference_timestamper.sv
// Samples NUM_CHANNELS channels on sample_tick, buffers {data, time} per
// channel and drains the buffers through a round-robin valid/ready port.
module multi_channel_reference_timestamper
    import midas_timestamper_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int LOG2_DEPTH   = 6,
    parameter int CHANGE_ONLY  = 1,
    localparam int CW          = chan_bits(NUM_CHANNELS)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               sample_tick,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] value,
    output logic                               timestamped_valid,
    input  logic                               timestamped_ready,
    output logic [DATA_WIDTH-1:0]              timestamped_bits_data,
    output logic [TIME_WIDTH-1:0]              timestamped_bits_time,
    output logic [CW-1:0]                      timestamped_bits_channel,
    output logic [NUM_CHANNELS-1:0]            overflow,
    output logic [TIME_WIDTH-1:0]              sample_count
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [TIME_WIDTH-1:0] tstamp;
    } entry_t;

    logic [TIME_WIDTH-1:0]                   count_q, count_d;
    logic [NUM_CHANNELS-1:0]                 seen_q, seen_d, ovf_q, ovf_d;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] last_q, last_d;
    logic [NUM_CHANNELS-1:0]                 record, fifo_full, fifo_empty, fifo_pop;
    entry_t [NUM_CHANNELS-1:0]               head;
    logic [DATA_WIDTH-1:0]                   chan_val;
    logic [CW-1:0]                           rr_ptr_q, rr_ptr_d, grant_q, grant_d;
    logic [CW-1:0]                           grant, idx;
    logic                                    hold_q, hold_d;
    logic                                    any_valid, fire, found;

    // Change detection; a channel's last value only moves on an accepted write.
    always_comb begin
        count_d  = count_q;
        seen_d   = seen_q;
        last_d   = last_q;
        ovf_d    = ovf_q;
        record   = '0;
        chan_val = '0;
        if (sample_tick) begin
            count_d = count_q + TIME_WIDTH'(1);
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                chan_val  = value[c*DATA_WIDTH +: DATA_WIDTH];
                record[c] = (CHANGE_ONLY == 0) || !seen_q[c] || (chan_val != last_q[c]);
                if (record[c]) begin
                    if (fifo_full[c]) begin
                        ovf_d[c] = 1'b1;
                    end else begin
                        seen_d[c] = 1'b1;
                        last_d[c] = chan_val;
                    end
                end
            end
        end
    end

    // Round-robin grant, frozen while an offer waits for ready.
    always_comb begin
        any_valid = |(~fifo_empty);
        grant     = rr_ptr_q;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            idx = CW'((int'(rr_ptr_q) + i) % NUM_CHANNELS);
            if (!found && !fifo_empty[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
        if (hold_q) begin
            grant = grant_q;
        end
        fire     = any_valid && timestamped_ready;
        hold_d   = any_valid && !timestamped_ready;
        grant_d  = grant;
        rr_ptr_d = rr_ptr_q;
        fifo_pop = '0;
        if (fire) begin
            fifo_pop[grant] = 1'b1;
            if (int'(grant) == NUM_CHANNELS - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant + CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q  <= '0;
            seen_q   <= '0;
            last_q   <= '0;
            ovf_q    <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            hold_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            seen_q   <= seen_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            hold_q   <= hold_d;
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_fifo
        timestamp_fifo #(
            .WIDTH      (DATA_WIDTH + TIME_WIDTH),
            .LOG2_DEPTH (LOG2_DEPTH)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (record[c]),
            .push_data ({value[c*DATA_WIDTH +: DATA_WIDTH], count_q}),
            .pop       (fifo_pop[c]),
            .full      (fifo_full[c]),
            .empty     (fifo_empty[c]),
            .head      (head[c])
        );
    end

    // Payload is forced to zero whenever nothing is offered.
    assign timestamped_valid        = any_valid;
    assign timestamped_bits_data    = any_valid ? head[grant].data : '0;
    assign timestamped_bits_time    = any_valid ? head[grant].tstamp : '0;
    assign timestamped_bits_channel = any_valid ? grant : '0;
    assign overflow                 = ovf_q;
    assign sample_count             = count_q;

endmodule
